naive_bus_uart_tx: RTL

// - naive_bus slave: UART transmitter with byte FIFO; sits directly downstream of naive_bus_router on one slave port.
// - CPU/DMA masters write bytes through the router; block serialises 8N1 (optional parity) on uart_tx.
// - Router passes masked local address; block decodes addr[3:2] only.

---
 rtl/naive_bus_uart_pkg.sv | 29 ++
 rtl/naive_bus_uart_tx_fifo.sv | 61 ++++++
 rtl/naive_bus_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/naive_bus_uart_pkg.sv
// Shared definitions for the naive_bus UART transmitter: register offsets, STATUS bits, tx FSM states.
// No logic; the baud divisor helper maps a programmed 0 onto the shortest legal bit time.
// No flow control here; it lives in the users of the package.
package naive_bus_uart_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_RSVD   = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_PARITY    = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/naive_bus_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter; dout shows the head entry combinationally.
// Latency: a pushed byte is visible at dout one cycle after the push edge.
// Backpressure: push is dropped when full, pop is dropped when empty; full/empty are registered.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/naive_bus_uart_tx.sv
// naive_bus slave UART transmitter, 8N1 (even parity frame when UART_TX_PARITY_EN is defined).
// Latency: rd_data one cycle after rd_req; start bit begins one cycle after a byte lands in an empty FIFO.
// Backpressure: wr_gnt drops only for TXDATA byte writes while the FIFO is full; reads always granted.
module naive_bus_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rd_req,
  input  logic [3:0]  rd_be,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_gnt,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_gnt,
  output logic        uart_tx
);

  import naive_bus_uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   div_q;
  logic [15:0]   bit_len;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  tx_state_t     state;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          wr_txdata;
  logic          wr_div;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign unused_bits = ^{rd_be, rd_addr[31:4], rd_addr[1:0], wr_addr[31:4], wr_addr[1:0],
                         wr_data[31:16], wr_be[3:2]};

  assign wr_txdata = wr_req && (wr_addr[3:2] == UART_TXDATA) && wr_be[0];
  assign wr_div    = wr_req && (wr_addr[3:2] == UART_DIV);
  assign wr_gnt    = !(wr_txdata && fifo_full);
  assign fifo_push = wr_txdata && !fifo_full;
  assign rd_gnt    = 1'b1;

  // Pop on frame start from idle, or at the end of a stop bit to chain frames with no gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == TX_IDLE) || ((state == TX_STOP) && (baud_cnt == 16'd0)));
  assign bit_len  = eff_div(div_q) - 16'd1;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_q <= DEFAULT_DIV;
    end else if (wr_div) begin
      if (wr_be[0]) div_q[7:0]  <= wr_data[7:0];
      if (wr_be[1]) div_q[15:8] <= wr_data[15:8];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr[3:2])
      UART_STATUS: begin
        rd_mux[STAT_FULL]               = fifo_full;
        rd_mux[STAT_EMPTY]              = fifo_empty;
        rd_mux[STAT_BUSY]               = (state != TX_IDLE);
        rd_mux[STAT_PARITY]             = PARITY_EN;
        rd_mux[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
      end
      UART_DIV: rd_mux[15:0] = div_q;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_req && rd_gnt) begin
      rd_data <= rd_mux;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else if (fifo_pop) begin
      parity_q <= ^fifo_dout;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= TX_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (fifo_pop) begin
            state    <= TX_START;
            shifter  <= fifo_dout;
            uart_tx  <= 1'b0;
            baud_cnt <= bit_len;
          end
        end
        default: begin
          if (baud_cnt != 16'd0) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            // The divisor is sampled only here, so a DIV write never stretches the current bit.
            baud_cnt <= bit_len;
            case (state)
              TX_START: begin
                state   <= TX_DATA;
                bit_idx <= 3'd0;
                uart_tx <= shifter[0];
              end
              TX_DATA: begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state   <= TX_PARITY;
                  uart_tx <= parity_q;
`else
                  state   <= TX_STOP;
                  uart_tx <= 1'b1;
`endif
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                  shifter <= {1'b0, shifter[7:1]};
                  uart_tx <= shifter[1];
                end
              end
`ifdef UART_TX_PARITY_EN
              TX_PARITY: begin
                state   <= TX_STOP;
                uart_tx <= 1'b1;
              end
`endif
              TX_STOP: begin
                if (fifo_pop) begin
                  state   <= TX_START;
                  shifter <= fifo_dout;
                  uart_tx <= 1'b0;
                end else begin
                  state   <= TX_IDLE;
                  uart_tx <= 1'b1;
                end
              end
              default: begin
                state   <= TX_IDLE;
                uart_tx <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
